// File: rtl/mux10.sv
// rtl/mux10.sv - registered 10-to-1 word multiplexer
//
// Purpose: steers one of ten WIDTH-bit inputs d0..d9 onto y, chosen by the
//   4-bit binary select s, with exactly one clock of latency. Selects
//   10..15 load OOR_VAL instead of any data input.
//
// Parameters:
//   WIDTH    data width of d0..d9 and y (>= 1)
//   OOR_VAL  value loaded into y for an out-of-range select
//
// Ports:
//   clk      clock, rising-edge
//   rst      synchronous reset, active-high
//   d0..d9   data inputs, dN selected when s == N
//   s        binary select, valid range 0..9
//   y        registered selected word
//   sel_err  registered out-of-range flag, aligned with y
//            (present only when MUX10_SEL_ERR_EN is defined)
//
// Optional feature macro: MUX10_SEL_ERR_EN
module mux10 #(
  parameter int unsigned        WIDTH   = 16,
  parameter logic [WIDTH-1:0]   OOR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d8,
  input  logic [WIDTH-1:0] d9,
  input  logic [3:0]       s,
`ifdef MUX10_SEL_ERR_EN
  output logic             sel_err,
`endif
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_q;

  // The select decode lives inside the clocked block so there is no
  // combinational path from any input to y. Each data input appears only
  // in its own case arm, so an unselected X/Z can never reach y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      case (s)
        4'd0:    y_q <= d0;
        4'd1:    y_q <= d1;
        4'd2:    y_q <= d2;
        4'd3:    y_q <= d3;
        4'd4:    y_q <= d4;
        4'd5:    y_q <= d5;
        4'd6:    y_q <= d6;
        4'd7:    y_q <= d7;
        4'd8:    y_q <= d8;
        4'd9:    y_q <= d9;
        default: y_q <= OOR_VAL;
      endcase
    end
  end

  assign y = y_q;

`ifdef MUX10_SEL_ERR_EN
  logic sel_err_q;

  // Flag is registered on the same edge as y so it marks exactly the
  // cycles where y carries OOR_VAL because of a bad select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= (s > 4'd9);
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux10.sv
// tb/tb_mux10.sv - directed self-checking bench for mux10
module tb_mux10;

  logic        clk;
  logic        rst;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [3:0]  s;
  logic [15:0] y;
`ifdef MUX10_SEL_ERR_EN
  logic        sel_err;
`endif

  int n_checks;
  int n_fails;

  logic [15:0] exp_list [10];

  mux10 #(.WIDTH(16), .OOR_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .d4  (d4),
    .d5  (d5),
    .d6  (d6),
    .d7  (d7),
    .d8  (d8),
    .d9  (d9),
    .s   (s),
`ifdef MUX10_SEL_ERR_EN
    .sel_err (sel_err),
`endif
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string tag, input logic [15:0] expv);
    n_checks++;
    assert (y === expv) else begin
      n_fails++;
      $error("FAIL %s: y observed %h expected %h", tag, y, expv);
    end
  endtask

  task automatic check_err(input string tag, input logic expv);
`ifdef MUX10_SEL_ERR_EN
    n_checks++;
    assert (sel_err === expv) else begin
      n_fails++;
      $error("FAIL %s: sel_err observed %b expected %b", tag, sel_err, expv);
    end
`else
    if (expv === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_list = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h0004,
                 16'h000E, 16'h000F, 16'h0001, 16'h0002, 16'h0003};

    {d0, d1, d2, d3, d4, d5, d6, d7, d8, d9} = '0;
    s   = 4'd3;
    d3  = 16'h000D;
    rst = 1'b1;

    // 1. reset holds y at zero for two edges
    tick; check_y("reset_edge1", 16'h0000); check_err("reset_err1", 1'b0);
    tick; check_y("reset_edge2", 16'h0000); check_err("reset_err2", 1'b0);

    // 2. sweep all valid selects
    d0 = 16'h000A; d1 = 16'h000B; d2 = 16'h000C; d3 = 16'h000D; d4 = 16'h0004;
    d5 = 16'h000E; d6 = 16'h000F; d7 = 16'h0001; d8 = 16'h0002; d9 = 16'h0003;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s = 4'(i);
      tick;
      check_y($sformatf("sweep_s%0d", i), exp_list[i]);
      check_err($sformatf("sweep_err%0d", i), 1'b0);
    end

    // latency: changing s between edges must not move y
    s = 4'd0;
    #2;
    check_y("no_comb_path", 16'h0003);

    // 3. out-of-range selects
    for (int i = 10; i < 16; i++) begin
      s = 4'(i);
      tick;
      check_y($sformatf("oor_s%0d", i), 16'h0000);
      check_err($sformatf("oor_err%0d", i), 1'b1);
    end
    s = 4'd5;
    tick; check_y("oor_recover", 16'h000E); check_err("oor_err_clear", 1'b0);

    // 4. unselected data changes never reach y
    s = 4'd2;
    tick; check_y("hold_s2", 16'h000C);
    d7 = 16'h1234;
    tick; check_y("d7_1234", 16'h000C);
    d7 = 16'h5678;
    tick; check_y("d7_5678", 16'h000C);
    d8 = 16'hxxxx;
    tick; check_y("unsel_x", 16'h000C);
    d8 = 16'h0002;
    d2 = 16'hBEEF;
    tick; check_y("d2_beef", 16'hBEEF);

    // 5. reset mid-stream then release
    s = 4'd9;
    tick; check_y("s9_pre_rst", 16'h0003);
    rst = 1'b1;
    tick; check_y("mid_rst", 16'h0000);
    rst = 1'b0;
    tick; check_y("rst_release", 16'h0003);

    // 6. select and data change on the same edge
    s = 4'd0;
    tick; check_y("s0_pre", 16'h000A);
    s  = 4'd9;
    d9 = 16'hFFFF;
    tick; check_y("simul_change", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
